// File: rtl/instruction_encoder_loader_if.sv
// Field-bundle handshake and instruction-memory write bus of the instruction encoder/loader.
// The master drives the field bundle and session control; the slave (loader) drives the memory port.
interface instruction_encoder_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            fmt;
  logic [6:0]            opcode;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [31:0]           imm;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  err_illegal;

  modport master (
    output start, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err_illegal
  );

  modport slave (
    input  start, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err_illegal
  );
endinterface

// File: rtl/instruction_encoder_loader.sv
// Packs RV32I field bundles into 32-bit instruction words and streams them into
// instruction memory at consecutive word addresses, one write per accepted bundle.
module instruction_encoder_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input logic                          clk,
  input logic                          rst,
  instruction_encoder_loader_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

  localparam logic [ADDR_WIDTH:0] LastIdx = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);

  state_e                state_q;
  logic                  in_ready_q;
  logic                  we_q;
  logic                  full_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH:0]   acc_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [31:0]           enc_d;
  logic                  illegal;
  logic                  accept;

  // start takes priority over a coincident bundle
  assign accept = bus.in_valid && (state_q == StLoad) && !bus.start;

  always_comb begin
    enc_d   = '0;
    illegal = 1'b0;
    case (bus.fmt)
      3'd0: enc_d = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd1: enc_d = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd2: enc_d = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
      3'd3: enc_d = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                     bus.imm[4:1], bus.imm[11], bus.opcode};
      3'd4: enc_d = {bus.imm[31:12], bus.rd, bus.opcode};
      3'd5: enc_d = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                     bus.rd, bus.opcode};
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      acc_q      <= '0;
      count_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (we_q) begin
        count_q <= count_q + 1'b1;
      end
      if (accept && illegal) begin
        err_q <= 1'b1;
      end
      // acc_q counts legal accepts, so it is also the address of the next word
      if (accept && !illegal) begin
        we_q    <= 1'b1;
        addr_q  <= acc_q[ADDR_WIDTH-1:0];
        wdata_q <= enc_d;
        acc_q   <= acc_q + 1'b1;
        if (acc_q == LastIdx) begin
          state_q    <= StFull;
          in_ready_q <= 1'b0;
          full_q     <= 1'b1;
        end
      end
      if (bus.start) begin
        state_q    <= StLoad;
        in_ready_q <= 1'b1;
        full_q     <= 1'b0;
        err_q      <= 1'b0;
        acc_q      <= '0;
        count_q    <= '0;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.err_illegal = err_q;

endmodule

// File: doc/instruction_encoder_loader.md
Name: instruction_encoder_loader

Overview:
Converts field-level RV32I instruction descriptions (format, opcode, register indices, funct, immediate) into packed 32-bit instruction words. Writes them sequentially into the instruction memory write port, so test programs and boot images can be loaded without hand-assembled hex. It is the inverse of the core's field decoder and sits between the bench/boot sequencer and instruction memory.

Parameters:
ADDR_WIDTH, 8, word-address width of the instruction memory write port
MEM_DEPTH, 256, number of words loadable per session; must be ≤ 2**ADDR_WIDTH and ≥ 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  pulse: begin a load session at word address 0
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle this cycle
fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J, 6-7 illegal
opcode  input  7  instruction[6:0]
rd  input  5  destination register index
rs1  input  5  source register 1 index
rs2  input  5  source register 2 index
funct3  input  3  instruction[14:12]
funct7  input  7  instruction[31:25] (R only)
imm  input  32  immediate, raw byte value (not pre-shifted)
mem_we  output  1  instruction memory write strobe
mem_addr  output  ADDR_WIDTH  word address for mem_wdata
mem_wdata  output  32  encoded instruction word
count  output  ADDR_WIDTH+1  words written this session
full  output  1  MEM_DEPTH words written; no further accepts
err_illegal  output  1  sticky: an illegal fmt was accepted

Behaviour:
- Reset: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err_illegal=0. rst overrides every other input, including mid-session; a pending write is dropped.
- States: IDLE, LOAD, FULL.
- IDLE: in_ready=0. On start, go to LOAD, clear the address pointer, count and err_illegal.
- LOAD: in_ready=1. An accept is in_valid && in_ready.
- Accept in cycle N: the encoded word is registered. In cycle N+1, mem_we=1, mem_addr=pointer, and mem_wdata=the word. The pointer and count increment at the end of cycle N+1.
- Back-to-back accepts are allowed every cycle; this gives one write per cycle with a 1-cycle latency.
- The accept that brings the number of accepted words to MEM_DEPTH moves the block to FULL in the next cycle. in_ready drops in that same cycle, while the last write is in progress.
- FULL: in_ready=0, full=1. start returns to LOAD with the pointer at 0, count 0 and full 0.
- start in LOAD restarts the session: pointer and count return to 0 and err_illegal is cleared. If start coincides with an accept, the start wins and the bundle is not accepted.
- Illegal fmt (6, 7) while accepting: the handshake completes but no write is issued, and the pointer and count do not advance. err_illegal sets next cycle and stays set until start or rst.
- Encoding, where {} means concatenation MSB first:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Field handling:
  - Unused fields for a format are ignored.
  - Immediate bits not listed for a format are ignored; there is no range check.
  - imm[0] is discarded for B and J.
  - No opcode/fmt consistency check.
- mem_addr holds its last value when mem_we=0. mem_wdata holds its last encoded value when mem_we=0.
- count saturates at MEM_DEPTH; the address pointer never wraps within a session.

Test Plan:
- Reset then start; R-format add x5,x6,x7 (opcode 0x33, rd 5, rs1 6, rs2 7, f3 0, f7 0) -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x007302B3; count=1.
- Back-to-back bundles, one per cycle:
  - addi x1,x0,-1 (I, imm 0xFFFFFFFF) -> 0xFFF00093 @0
  - sw x2,8(x3) (S, op 0x23, f3 2) -> 0x0021A423 @1
  - beq x0,x0,-4 (B, op 0x63, imm 0xFFFFFFFC) -> 0xFE000EE3 @2
  - lui x10,0x12345 (U, op 0x37, imm 0x12345000) -> 0x12345537 @3
  - jal x1,8 (J, op 0x6F, imm 8) -> 0x008000EF @4
  - Required: five consecutive mem_we cycles, count=5.
- MEM_DEPTH=4, keep in_valid high -> exactly 4 writes to addr 0-3, in_ready low from the cycle after the 4th accept, full=1. Pulse start -> in_ready=1, count=0, next write lands at addr 0.
- fmt=6 accepted between two valid R bundles -> no write for it, err_illegal=1 next cycle, the two valid words land at consecutive addresses 0 and 1. A later start clears err_illegal.
- Assert rst in the cycle after an accept -> no mem_we the following cycle, all outputs at reset values, in_ready=0 until start.
- start asserted together with in_valid mid-session (count=3) -> bundle not accepted, count=0; the next accepted bundle writes addr 0.
